// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch/decode pipeline register.
//   NOP_ENC      : encoding driven to decode as a bubble
//   IMM_BIT_DEF  : default opcode bit that marks a two-word instruction
//   ST_IDLE / ST_WAIT_IMM : FSM state encoding
package if_id_stage_pkg;
  localparam logic [15:0] NOP_ENC     = 16'h0000;
  localparam int          IMM_BIT_DEF = 15;
  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_WAIT_IMM = 1'b1;
endpackage

// File: rtl/if_id_stage_reg.sv
// Generic enable/reset register used for every storage element of the stage.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low, loads RST_VAL
//   en   : load enable
//   d    : next value
//   q    : stored value
module if_id_stage_reg #(
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register. Captures instruction, PC and PC+1 from fetch and
// assembles two-word instructions (opcode word with IMM_BIT set, followed by
// an immediate word). Decode sees a bubble while the immediate is collected.
// Optional feature: define IF_ID_BUBBLE_CNT_EN to add the 16-bit saturating
// bubble_cnt output.
// Ports:
//   clk, rst (async, active-low), stall (hold), flush (squash, beats stall)
//   instr_in, imm_in, pc_in, pc_1_in : from fetch
//   instr_out, imm_out, pc_out, pc_1_out, valid_out : to decode
//   imm_pending : high while the immediate word is being captured
//   bubble_cnt  : (optional) count of bubbles loaded into the output bank
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int           W       = 16,
  parameter int           IMM_BIT = IMM_BIT_DEF,
  parameter logic [W-1:0] NOP     = W'(NOP_ENC)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic [W-1:0]   instr_in,
  input  logic [W-1:0]   imm_in,
  input  logic [2*W-1:0] pc_in,
  input  logic [2*W-1:0] pc_1_in,
  output logic [W-1:0]   instr_out,
  output logic [W-1:0]   imm_out,
  output logic [2*W-1:0] pc_out,
  output logic [2*W-1:0] pc_1_out,
  output logic           valid_out,
`ifdef IF_ID_BUBBLE_CNT_EN
  output logic [15:0]    bubble_cnt,
`endif
  output logic           imm_pending
);
  localparam int BANK_W = 6*W + 1;
  localparam logic [BANK_W-1:0] BANK_RST = {NOP, {(5*W+1){1'b0}}};

  logic [0:0]        state, state_nxt;
  logic [W-1:0]      hold_op;
  logic [2*W-1:0]    hold_pc;
  logic              en, hold_en;
  logic [W-1:0]      instr_p1, imm_p1;
  logic [2*W-1:0]    pc_p1, pc_1_p1;
  logic              vld_p1;
  logic [BANK_W-1:0] bank_q;

  // Flush overrides stall, so the stage advances on either.
  assign en      = flush | ~stall;
  assign hold_en = ~flush & ~stall & (state == ST_IDLE) & instr_in[IMM_BIT];

  always_comb begin
    state_nxt = state;
    instr_p1  = instr_out;
    imm_p1    = imm_out;
    pc_p1     = pc_out;
    pc_1_p1   = pc_1_out;
    vld_p1    = valid_out;
    if (flush) begin
      // PCs are deliberately left untouched on a squash.
      state_nxt = ST_IDLE;
      instr_p1  = NOP;
      imm_p1    = '0;
      vld_p1    = 1'b0;
    end else if (state == ST_WAIT_IMM) begin
      // instr_in is ignored here; imm_in carries the immediate word.
      state_nxt = ST_IDLE;
      instr_p1  = hold_op;
      imm_p1    = imm_in;
      pc_p1     = hold_pc;
      pc_1_p1   = pc_1_in;
      vld_p1    = 1'b1;
    end else if (instr_in[IMM_BIT]) begin
      state_nxt = ST_WAIT_IMM;
      instr_p1  = NOP;
      imm_p1    = '0;
      vld_p1    = 1'b0;
    end else begin
      instr_p1  = instr_in;
      imm_p1    = '0;
      pc_p1     = pc_in;
      pc_1_p1   = pc_1_in;
      vld_p1    = 1'b1;
    end
  end

  // ---- stage p0 -> p1 boundary ----
  if_id_stage_reg #(.DATA_W(1), .RST_VAL(ST_IDLE)) u_state (
    .clk(clk), .rst(rst), .en(en), .d(state_nxt), .q(state)
  );

  if_id_stage_reg #(.DATA_W(W), .RST_VAL(NOP)) u_hold_op (
    .clk(clk), .rst(rst), .en(hold_en), .d(instr_in), .q(hold_op)
  );

  if_id_stage_reg #(.DATA_W(2*W), .RST_VAL('0)) u_hold_pc (
    .clk(clk), .rst(rst), .en(hold_en), .d(pc_in), .q(hold_pc)
  );

  if_id_stage_reg #(.DATA_W(BANK_W), .RST_VAL(BANK_RST)) u_out_bank (
    .clk(clk), .rst(rst), .en(en),
    .d({instr_p1, imm_p1, pc_p1, pc_1_p1, vld_p1}),
    .q(bank_q)
  );

  assign {instr_out, imm_out, pc_out, pc_1_out, valid_out} = bank_q;
  assign imm_pending = (state == ST_WAIT_IMM);

`ifdef IF_ID_BUBBLE_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] bcnt_nxt;

  // Counts every advancing edge that loads a bubble into the output bank.
  always_comb begin
    bcnt_nxt = bubble_cnt;
    if (en && !vld_p1) bcnt_nxt = sat_inc16(bubble_cnt);
  end

  if_id_stage_reg #(.DATA_W(16), .RST_VAL('0)) u_bubble_cnt (
    .clk(clk), .rst(rst), .en(1'b1), .d(bcnt_nxt), .q(bubble_cnt)
  );
`endif

endmodule
